// File: rtl/ffe_sample_writer.sv
// Input-side writer for the FFE sample delay line: circular sample history with
// x[n-k] tap reads and a per-sample frame strobe toward the FFE controller.
module ffe_sample_writer #(
    parameter int IN_OUT_BUS_WIDTH = 12,
    parameter int DEPTH            = 4,
    parameter int ADDR_SIZE        = $clog2(DEPTH)
) (
    input  logic                               ffe_clk,
    input  logic                               rst,
    input  logic signed [IN_OUT_BUS_WIDTH-1:0] x_in,
    input  logic                               x_valid,
    output logic                               x_ready,
    input  logic                               flush,
    input  logic                               frame_busy,
    input  logic        [ADDR_SIZE-1:0]        rd_addr,
    output logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data,
    output logic                               sample_strobe,
    output logic        [ADDR_SIZE:0]          fill_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    localparam logic [ADDR_SIZE-1:0] PTR_LAST = ADDR_SIZE'(DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   FILL_MAX = (ADDR_SIZE + 1)'(DEPTH);

    state_e                               state_q, state_d;
    logic                                 ready_q, ready_d;
    logic                                 strobe_q, strobe_d;
    logic        [ADDR_SIZE-1:0]          wr_ptr_q, wr_ptr_d;
    logic        [ADDR_SIZE-1:0]          last_ptr_q, last_ptr_d;
    logic        [ADDR_SIZE:0]            fill_q, fill_d;
    logic signed [IN_OUT_BUS_WIDTH-1:0]   mem_q [DEPTH];
    logic signed [IN_OUT_BUS_WIDTH-1:0]   mem_d [DEPTH];
    logic                                 xfer_s;
    logic        [ADDR_SIZE-1:0]          rd_idx_s;

    // Flush blocks acceptance in the same cycle so a colliding sample stays upstream.
    assign x_ready       = ready_q & ~flush;
    assign xfer_s        = x_valid & x_ready;
    assign sample_strobe = strobe_q;
    assign fill_cnt      = fill_q;

    // Next-state logic for the frame FSM and the sample history.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        strobe_d   = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        last_ptr_d = last_ptr_q;
        fill_d     = fill_q;
        mem_d      = mem_q;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d   = '0;
            last_ptr_d = '0;
            fill_d     = '0;
            state_d    = ST_IDLE;
            ready_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer_s) begin
                        mem_d[wr_ptr_q] = x_in;
                        last_ptr_d      = wr_ptr_q;
                        if (wr_ptr_q == PTR_LAST) begin
                            wr_ptr_d = '0;
                        end else begin
                            wr_ptr_d = wr_ptr_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
                        end
                        if (fill_q == FILL_MAX) begin
                            fill_d = fill_q;
                        end else begin
                            fill_d = fill_q + {{ADDR_SIZE{1'b0}}, 1'b1};
                        end
                        state_d  = ST_STROBE;
                        ready_d  = 1'b0;
                        strobe_d = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                    end
                end
                ST_STROBE: begin
                    state_d = ST_WAIT;
                    ready_d = 1'b0;
                end
                ST_WAIT: begin
                    if (!frame_busy) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        ready_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset dominates flush and every other input.
    always_ff @(posedge ffe_clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            strobe_q   <= 1'b0;
            wr_ptr_q   <= '0;
            last_ptr_q <= '0;
            fill_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            strobe_q   <= strobe_d;
            wr_ptr_q   <= wr_ptr_d;
            last_ptr_q <= last_ptr_d;
            fill_q     <= fill_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Tap read: k samples back from the newest, zero beyond the stored history.
    always_comb begin
        rd_idx_s = '0;
        rd_data  = '0;
        if (last_ptr_q >= rd_addr) begin
            rd_idx_s = last_ptr_q - rd_addr;
        end else begin
            rd_idx_s = ADDR_SIZE'({1'b0, last_ptr_q} + FILL_MAX - {1'b0, rd_addr});
        end
        if ({1'b0, rd_addr} < fill_q) begin
            rd_data = mem_q[rd_idx_s];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: tb/tb_ffe_sample_writer.sv
// Directed self-checking bench for ffe_sample_writer.
`timescale 1ns/100ps
module tb_ffe_sample_writer;

    logic               ffe_clk;
    logic               rst;
    logic signed [11:0] x_in;
    logic               x_valid;
    logic               x_ready;
    logic               flush;
    logic               frame_busy;
    logic        [1:0]  rd_addr;
    logic signed [11:0] rd_data;
    logic               sample_strobe;
    logic        [2:0]  fill_cnt;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_strb = 0;
    int last_wait = 0;
    int strb_mark = 0;

    ffe_sample_writer #(.IN_OUT_BUS_WIDTH(12), .DEPTH(4)) dut (
        .ffe_clk      (ffe_clk),
        .rst          (rst),
        .x_in         (x_in),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .flush        (flush),
        .frame_busy   (frame_busy),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .sample_strobe(sample_strobe),
        .fill_cnt     (fill_cnt)
    );

    initial ffe_clk = 1'b0;
    always #5 ffe_clk = ~ffe_clk;

    always @(posedge ffe_clk) begin
        if (sample_strobe === 1'b1) n_strb++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ffe_clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input int k, input int exp);
        rd_addr = 2'(k);
        #0.2;
        check(tag, rd_data, exp);
    endtask

    task automatic rd_all(input string tag, input int e0, input int e1, input int e2, input int e3);
        rd_check({tag, "_k0"}, 0, e0);
        rd_check({tag, "_k1"}, 1, e1);
        rd_check({tag, "_k2"}, 2, e2);
        rd_check({tag, "_k3"}, 3, e3);
    endtask

    task automatic send(input int v, input int busy);
        int w;
        w = 0;
        x_in = 12'(v);
        x_valid = 1'b1;
        while (!x_ready && w < 20) begin
            step();
            w++;
        end
        check("send_ready", x_ready, 1);
        last_wait = w;
        step();
        x_valid = 1'b0;
        check("strobe_hi", sample_strobe, 1);
        frame_busy = 1'b1;
        step();
        check("strobe_lo", sample_strobe, 0);
        check("wait_not_ready", x_ready, 0);
        repeat (busy - 1) step();
        frame_busy = 1'b0;
        step();
        check("ready_back", x_ready, 1);
    endtask

    initial begin
        rst = 1'b0; x_in = '0; x_valid = 1'b0; flush = 1'b0;
        frame_busy = 1'b0; rd_addr = '0;

        // reset and idle
        step(); step();
        check("rst_ready", x_ready, 0);
        check("rst_fill", fill_cnt, 0);
        check("rst_strobe", sample_strobe, 0);
        rd_all("rst_rd", 0, 0, 0, 0);
        rst = 1'b1;
        #0.2;
        check("rst_rel_ready_pre", x_ready, 0);
        step();
        check("rst_rel_ready", x_ready, 1);

        // single sample
        strb_mark = n_strb;
        send(100, 4);
        check("single_fill", fill_cnt, 1);
        rd_all("single_rd", 100, 0, 0, 0);
        step();
        check("single_strobe_cnt", n_strb - strb_mark, 1);

        // fill and wrap
        send(10, 4);
        check("fill2", fill_cnt, 2);
        rd_all("fill2_rd", 10, 100, 0, 0);
        send(-20, 4);
        send(30, 4);
        send(-40, 4);
        check("fill_sat4", fill_cnt, 4);
        rd_all("full_rd", -40, 30, -20, 10);
        send(50, 4);
        check("wrap_fill", fill_cnt, 4);
        rd_all("wrap_rd", 50, -40, 30, -20);

        // flush colliding with a valid sample in IDLE
        strb_mark = n_strb;
        flush = 1'b1; x_valid = 1'b1; x_in = 12'sd55;
        #0.2;
        check("flush_ready_comb", x_ready, 0);
        step();
        flush = 1'b0;
        check("flush_fill", fill_cnt, 0);
        check("flush_strobe", sample_strobe, 0);
        rd_all("flush_rd", 0, 0, 0, 0);
        check("flush_no_strobe_cnt", n_strb - strb_mark, 0);
        send(55, 2);
        check("flush_next_accept_wait", last_wait, 0);
        check("flush_next_fill", fill_cnt, 1);
        rd_check("flush_next_rd0", 0, 55);

        // back-pressure: second sample held valid through WAIT
        strb_mark = n_strb;
        x_valid = 1'b1; x_in = 12'sd11;
        step();
        x_in = 12'sd7;
        check("bp_strobe1", sample_strobe, 1);
        check("bp_fill_a", fill_cnt, 2);
        frame_busy = 1'b1;
        step(); step(); step();
        check("bp_wait_ready", x_ready, 0);
        check("bp_wait_fill", fill_cnt, 2);
        rd_check("bp_wait_rd0", 0, 11);
        frame_busy = 1'b0;
        step();
        check("bp_ready_back", x_ready, 1);
        check("bp_no_early_write", fill_cnt, 2);
        step();
        x_valid = 1'b0;
        check("bp_strobe2", sample_strobe, 1);
        check("bp_fill_b", fill_cnt, 3);
        rd_all("bp_rd", 7, 11, 55, 0);
        frame_busy = 1'b1;
        step(); step();
        check("bp_strobe_cnt", n_strb - strb_mark, 2);
        check("bp_single_write_fill", fill_cnt, 3);

        // reset in the middle of a frame (WAIT, 3 samples stored)
        strb_mark = n_strb;
        rst = 1'b0;
        step();
        rst = 1'b1;
        frame_busy = 1'b0;
        check("mid_rst_fill", fill_cnt, 0);
        check("mid_rst_ready", x_ready, 0);
        check("mid_rst_strobe", sample_strobe, 0);
        rd_all("mid_rst_rd", 0, 0, 0, 0);
        step();
        check("mid_rst_ready_back", x_ready, 1);
        step(); step();
        check("mid_rst_no_strobe", n_strb - strb_mark, 0);
        send(-2048, 2);
        check("neg_fill", fill_cnt, 1);
        rd_all("neg_rd", -2048, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
